// File: rtl/instr_decode_queue_pkg.sv
// Shared definitions for the buffered RV32I decode stage.
// Holds the major opcode constants, the operation-type codes carried with
// every decoded micro-op, the register index type, and the control part of
// a queue slot.
package instr_decode_queue_pkg;

    typedef logic [5:0] OPCODE_TYPE;
    typedef logic [4:0] REG_RANGE;

    localparam REG_RANGE REG_ZERO = 5'd0;

    // Major opcodes (instr[6:0])
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    // NOP is code 0 so an empty queue's zeroed outputs read as a NOP
    localparam OPCODE_TYPE OPTYPE_NOP   = 6'd0;
    localparam OPCODE_TYPE OPTYPE_LUI   = 6'd1;
    localparam OPCODE_TYPE OPTYPE_AUIPC = 6'd2;
    localparam OPCODE_TYPE OPTYPE_JAL   = 6'd3;
    localparam OPCODE_TYPE OPTYPE_JALR  = 6'd4;
    localparam OPCODE_TYPE OPTYPE_BEQ   = 6'd5;
    localparam OPCODE_TYPE OPTYPE_BNE   = 6'd6;
    localparam OPCODE_TYPE OPTYPE_BLT   = 6'd7;
    localparam OPCODE_TYPE OPTYPE_BGE   = 6'd8;
    localparam OPCODE_TYPE OPTYPE_BLTU  = 6'd9;
    localparam OPCODE_TYPE OPTYPE_BGEU  = 6'd10;
    localparam OPCODE_TYPE OPTYPE_LB    = 6'd11;
    localparam OPCODE_TYPE OPTYPE_LH    = 6'd12;
    localparam OPCODE_TYPE OPTYPE_LW    = 6'd13;
    localparam OPCODE_TYPE OPTYPE_LBU   = 6'd14;
    localparam OPCODE_TYPE OPTYPE_LHU   = 6'd15;
    localparam OPCODE_TYPE OPTYPE_SB    = 6'd16;
    localparam OPCODE_TYPE OPTYPE_SH    = 6'd17;
    localparam OPCODE_TYPE OPTYPE_SW    = 6'd18;
    localparam OPCODE_TYPE OPTYPE_ADDI  = 6'd19;
    localparam OPCODE_TYPE OPTYPE_SLTI  = 6'd20;
    localparam OPCODE_TYPE OPTYPE_SLTIU = 6'd21;
    localparam OPCODE_TYPE OPTYPE_XORI  = 6'd22;
    localparam OPCODE_TYPE OPTYPE_ORI   = 6'd23;
    localparam OPCODE_TYPE OPTYPE_ANDI  = 6'd24;
    localparam OPCODE_TYPE OPTYPE_SLLI  = 6'd25;
    localparam OPCODE_TYPE OPTYPE_SRLI  = 6'd26;
    localparam OPCODE_TYPE OPTYPE_SRAI  = 6'd27;
    localparam OPCODE_TYPE OPTYPE_ADD   = 6'd28;
    localparam OPCODE_TYPE OPTYPE_SUB   = 6'd29;
    localparam OPCODE_TYPE OPTYPE_SLL   = 6'd30;
    localparam OPCODE_TYPE OPTYPE_SLT   = 6'd31;
    localparam OPCODE_TYPE OPTYPE_SLTU  = 6'd32;
    localparam OPCODE_TYPE OPTYPE_XOR   = 6'd33;
    localparam OPCODE_TYPE OPTYPE_SRL   = 6'd34;
    localparam OPCODE_TYPE OPTYPE_SRA   = 6'd35;
    localparam OPCODE_TYPE OPTYPE_OR    = 6'd36;
    localparam OPCODE_TYPE OPTYPE_AND   = 6'd37;

    // Control portion of a queue slot (imm and pc are stored separately
    // because their width follows XLEN)
    typedef struct packed {
        logic       illegal;
        logic       is_ls;
        logic       is_jump;
        logic       pred_jump;
        OPCODE_TYPE optype;
        REG_RANGE   rd;
        REG_RANGE   rs1;
        REG_RANGE   rs2;
    } uop_ctrl_t;

endpackage

// File: rtl/instr_decode_queue_rv32i_decode_core.sv
// rv32i_decode_core: purely combinational RV32I (no FENCE/SYSTEM) decoder.
// Ports:
//   instr   in   raw instruction
//   optype  out  operation code (OPTYPE_NOP when illegal)
//   rd/rs1/rs2 out register indices, forced to 0 where unused
//   imm     out  sign-extended immediate
//   is_ls, is_jump, illegal out decoded flags
module rv32i_decode_core
    import instr_decode_queue_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] instr,
    output OPCODE_TYPE      optype,
    output REG_RANGE        rd,
    output REG_RANGE        rs1,
    output REG_RANGE        rs2,
    output logic [XLEN-1:0] imm,
    output logic            is_ls,
    output logic            is_jump,
    output logic            illegal
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    OPCODE_TYPE      optype_d;
    REG_RANGE        rd_d, rs1_d, rs2_d;
    logic [XLEN-1:0] imm_d;
    logic            is_ls_d, is_jump_d;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];

    assign imm_i = {{(XLEN-11){instr[31]}}, instr[30:20]};
    assign imm_s = {{(XLEN-11){instr[31]}}, instr[30:25], instr[11:7]};
    assign imm_b = {{(XLEN-12){instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {{(XLEN-31){instr[31]}}, instr[30:12], 12'd0};
    assign imm_j = {{(XLEN-20){instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};

    // Field decode per opcode; illegal results are masked below
    always_comb begin
        optype_d  = OPTYPE_NOP;
        rd_d      = REG_ZERO;
        rs1_d     = REG_ZERO;
        rs2_d     = REG_ZERO;
        imm_d     = '0;
        is_ls_d   = 1'b0;
        is_jump_d = 1'b0;
        illegal   = 1'b0;
        case (opcode)
            OPC_LUI, OPC_AUIPC: begin
                optype_d = instr[5] ? OPTYPE_LUI : OPTYPE_AUIPC;
                rd_d     = instr[11:7];
                imm_d    = imm_u;
            end
            OPC_JAL: begin
                optype_d  = OPTYPE_JAL;
                rd_d      = instr[11:7];
                imm_d     = imm_j;
                is_jump_d = 1'b1;
            end
            OPC_JALR: begin
                optype_d  = OPTYPE_JALR;
                rd_d      = instr[11:7];
                rs1_d     = instr[19:15];
                imm_d     = imm_i;
                is_jump_d = 1'b1;
            end
            OPC_BRANCH: begin
                rs1_d     = instr[19:15];
                rs2_d     = instr[24:20];
                imm_d     = imm_b;
                is_jump_d = 1'b1;
                case (funct3)
                    3'b000:  optype_d = OPTYPE_BEQ;
                    3'b001:  optype_d = OPTYPE_BNE;
                    3'b100:  optype_d = OPTYPE_BLT;
                    3'b101:  optype_d = OPTYPE_BGE;
                    3'b110:  optype_d = OPTYPE_BLTU;
                    3'b111:  optype_d = OPTYPE_BGEU;
                    default: illegal  = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                rd_d    = instr[11:7];
                rs1_d   = instr[19:15];
                imm_d   = imm_i;
                is_ls_d = 1'b1;
                case (funct3)
                    3'b000:  optype_d = OPTYPE_LB;
                    3'b001:  optype_d = OPTYPE_LH;
                    3'b010:  optype_d = OPTYPE_LW;
                    3'b100:  optype_d = OPTYPE_LBU;
                    3'b101:  optype_d = OPTYPE_LHU;
                    default: illegal  = 1'b1;
                endcase
            end
            OPC_STORE: begin
                rs1_d   = instr[19:15];
                rs2_d   = instr[24:20];
                imm_d   = imm_s;
                is_ls_d = 1'b1;
                case (funct3)
                    3'b000:  optype_d = OPTYPE_SB;
                    3'b001:  optype_d = OPTYPE_SH;
                    3'b010:  optype_d = OPTYPE_SW;
                    default: illegal  = 1'b1;
                endcase
            end
            OPC_OP_IMM: begin
                rd_d  = instr[11:7];
                rs1_d = instr[19:15];
                imm_d = imm_i;
                case (funct3)
                    3'b000:  optype_d = OPTYPE_ADDI;
                    3'b001:  optype_d = OPTYPE_SLLI;
                    3'b010:  optype_d = OPTYPE_SLTI;
                    3'b011:  optype_d = OPTYPE_SLTIU;
                    3'b100:  optype_d = OPTYPE_XORI;
                    3'b101:  optype_d = instr[30] ? OPTYPE_SRAI : OPTYPE_SRLI;
                    3'b110:  optype_d = OPTYPE_ORI;
                    3'b111:  optype_d = OPTYPE_ANDI;
                    default: optype_d = OPTYPE_NOP;
                endcase
            end
            OPC_OP: begin
                rd_d  = instr[11:7];
                rs1_d = instr[19:15];
                rs2_d = instr[24:20];
                case (funct3)
                    3'b000:  optype_d = instr[30] ? OPTYPE_SUB : OPTYPE_ADD;
                    3'b001:  optype_d = OPTYPE_SLL;
                    3'b010:  optype_d = OPTYPE_SLT;
                    3'b011:  optype_d = OPTYPE_SLTU;
                    3'b100:  optype_d = OPTYPE_XOR;
                    3'b101:  optype_d = instr[30] ? OPTYPE_SRA : OPTYPE_SRL;
                    3'b110:  optype_d = OPTYPE_OR;
                    3'b111:  optype_d = OPTYPE_AND;
                    default: optype_d = OPTYPE_NOP;
                endcase
            end
            default: illegal = 1'b1;
        endcase
    end

    // An illegal instruction carries no operands or flags at all
    assign optype  = illegal ? OPTYPE_NOP : optype_d;
    assign rd      = illegal ? REG_ZERO : rd_d;
    assign rs1     = illegal ? REG_ZERO : rs1_d;
    assign rs2     = illegal ? REG_ZERO : rs2_d;
    assign imm     = illegal ? '0 : imm_d;
    assign is_ls   = illegal ? 1'b0 : is_ls_d;
    assign is_jump = illegal ? 1'b0 : is_jump_d;

endmodule

// File: rtl/instr_decode_queue.sv
// instr_decode_queue: decode-on-enqueue circular queue of micro-ops.
// Ports:
//   clk_in, rst_in (async, active-high), rdy_in (global freeze when low),
//   flush_in (clears queue next edge)
//   in_valid/in_ready with in_instr, in_pc, in_pred_jump from fetch
//   out_valid/out_ready with decoded head fields towards dispatch
module instr_decode_queue
    import instr_decode_queue_pkg::*;
#(
    parameter int DEPTH_LOG = 3,
    parameter int XLEN      = 32
) (
    input  logic            clk_in,
    input  logic            rst_in,
    input  logic            rdy_in,
    input  logic            flush_in,
    input  logic            in_valid,
    input  logic [XLEN-1:0] in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic            in_pred_jump,
    output logic            in_ready,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_is_ls,
    output logic            out_is_jump,
    output logic            out_illegal,
    output logic            out_pred_jump,
    output OPCODE_TYPE      out_optype,
    output REG_RANGE        out_rd,
    output REG_RANGE        out_rs1,
    output REG_RANGE        out_rs2,
    output logic [XLEN-1:0] out_imm,
    output logic [XLEN-1:0] out_pc
);

    localparam int DEPTH = 1 << DEPTH_LOG;
    localparam logic [DEPTH_LOG:0] FULL_COUNT = (DEPTH_LOG+1)'(1) << DEPTH_LOG;

    logic [DEPTH_LOG-1:0] head, tail;
    logic [DEPTH_LOG:0]   count;

    uop_ctrl_t       mem_ctrl [DEPTH];
    logic [XLEN-1:0] mem_imm  [DEPTH];
    logic [XLEN-1:0] mem_pc   [DEPTH];

    uop_ctrl_t       dec_ctrl;
    logic [XLEN-1:0] dec_imm;
    logic            push, pop, not_empty;

    rv32i_decode_core #(.XLEN(XLEN)) u_decode (
        .instr   (in_instr),
        .optype  (dec_ctrl.optype),
        .rd      (dec_ctrl.rd),
        .rs1     (dec_ctrl.rs1),
        .rs2     (dec_ctrl.rs2),
        .imm     (dec_imm),
        .is_ls   (dec_ctrl.is_ls),
        .is_jump (dec_ctrl.is_jump),
        .illegal (dec_ctrl.illegal)
    );
    assign dec_ctrl.pred_jump = in_pred_jump;

    // Handshakes depend only on registered count, so a pop never frees a
    // slot for a push in the same cycle
    assign not_empty = (count != '0);
    assign in_ready  = (count != FULL_COUNT) && rdy_in;
    assign out_valid = not_empty && rdy_in;
    assign push      = in_valid && in_ready && !flush_in;
    assign pop       = out_valid && out_ready && !flush_in;

    // Pointer and occupancy update; flush outranks push and pop
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush_in) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    // Slot storage (deliberately not reset)
    always_ff @(posedge clk_in) begin
        if (push) begin
            mem_ctrl[tail] <= dec_ctrl;
            mem_imm[tail]  <= dec_imm;
            mem_pc[tail]   <= in_pc;
        end
    end

    // Head read-out, zeroed whenever the queue is empty
    always_comb begin
        if (not_empty) begin
            out_is_ls     = mem_ctrl[head].is_ls;
            out_is_jump   = mem_ctrl[head].is_jump;
            out_illegal   = mem_ctrl[head].illegal;
            out_pred_jump = mem_ctrl[head].pred_jump;
            out_optype    = mem_ctrl[head].optype;
            out_rd        = mem_ctrl[head].rd;
            out_rs1       = mem_ctrl[head].rs1;
            out_rs2       = mem_ctrl[head].rs2;
            out_imm       = mem_imm[head];
            out_pc        = mem_pc[head];
        end else begin
            out_is_ls     = 1'b0;
            out_is_jump   = 1'b0;
            out_illegal   = 1'b0;
            out_pred_jump = 1'b0;
            out_optype    = OPTYPE_NOP;
            out_rd        = REG_ZERO;
            out_rs1       = REG_ZERO;
            out_rs2       = REG_ZERO;
            out_imm       = '0;
            out_pc        = '0;
        end
    end

endmodule

// File: tb/tb_instr_decode_queue.sv
// Directed bench for instr_decode_queue with a scoreboard of expected
// micro-ops: entries are queued when a push is accepted and compared when
// dispatch pops the head.
module tb_instr_decode_queue;
    import instr_decode_queue_pkg::*;

    typedef struct packed {
        logic [5:0]  optype;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic        pred;
        logic        ls;
        logic        jmp;
        logic        ill;
    } exp_t;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, flush_in, in_valid, in_pred_jump, out_ready;
    logic [31:0] in_instr, in_pc;
    logic        in_ready, out_valid, out_is_ls, out_is_jump, out_illegal, out_pred_jump;
    OPCODE_TYPE  out_optype;
    REG_RANGE    out_rd, out_rs1, out_rs2;
    logic [31:0] out_imm, out_pc;

    int checks = 0;
    int errors = 0;
    exp_t sb[$];

    instr_decode_queue #(.DEPTH_LOG(3), .XLEN(32)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
        .in_valid(in_valid), .in_instr(in_instr), .in_pc(in_pc),
        .in_pred_jump(in_pred_jump), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_is_ls(out_is_ls), .out_is_jump(out_is_jump),
        .out_illegal(out_illegal), .out_pred_jump(out_pred_jump),
        .out_optype(out_optype), .out_rd(out_rd), .out_rs1(out_rs1),
        .out_rs2(out_rs2), .out_imm(out_imm), .out_pc(out_pc)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic [5:0] optype, input logic [4:0] rd,
                                input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [31:0] imm, input logic [31:0] pc,
                                input logic pred, input logic ls, input logic jmp,
                                input logic ill);
        exp_t e;
        e.optype = optype; e.rd = rd; e.rs1 = rs1; e.rs2 = rs2; e.imm = imm;
        e.pc = pc; e.pred = pred; e.ls = ls; e.jmp = jmp; e.ill = ill;
        return e;
    endfunction

    // ADDI x1, x0, k
    function automatic logic [31:0] addi_instr(input logic [11:0] k);
        return {k, 5'd0, 3'b000, 5'd1, 7'b0010011};
    endfunction

    function automatic exp_t addi_exp(input logic [11:0] k, input logic [31:0] pc);
        return mk(OPTYPE_ADDI, 5'd1, 5'd0, 5'd0, {{20{k[11]}}, k}, pc, 1'b0, 1'b0, 1'b0, 1'b0);
    endfunction

    // One clock cycle: drive, check pre-edge outputs against the model,
    // clock, then advance the model. Called at posedge+1.
    task automatic step(input string tag, input bit do_push, input logic [31:0] instr,
                        input exp_t e, input bit do_pop, input bit do_flush, input bit rdy);
        bit push_ok, pop_ok;
        exp_t h;
        in_valid     = do_push;
        in_instr     = instr;
        in_pc        = e.pc;
        in_pred_jump = e.pred;
        out_ready    = do_pop;
        flush_in     = do_flush;
        rdy_in       = rdy;
        #1;
        chk({tag, ".in_ready"},  32'(in_ready),  32'(rdy && sb.size() < 8));
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(rdy && sb.size() != 0));
        if (sb.size() == 0) begin
            chk({tag, ".empty_pc"},     out_pc,             32'd0);
            chk({tag, ".empty_optype"}, 32'(out_optype),    32'(OPTYPE_NOP));
        end
        if (do_pop && rdy && sb.size() != 0) begin
            h = sb[0];
            chk({tag, ".optype"}, 32'(out_optype),    32'(h.optype));
            chk({tag, ".rd"},     32'(out_rd),        32'(h.rd));
            chk({tag, ".rs1"},    32'(out_rs1),       32'(h.rs1));
            chk({tag, ".rs2"},    32'(out_rs2),       32'(h.rs2));
            chk({tag, ".imm"},    out_imm,            h.imm);
            chk({tag, ".pc"},     out_pc,             h.pc);
            chk({tag, ".pred"},   32'(out_pred_jump), 32'(h.pred));
            chk({tag, ".is_ls"},  32'(out_is_ls),     32'(h.ls));
            chk({tag, ".is_jmp"}, 32'(out_is_jump),   32'(h.jmp));
            chk({tag, ".illeg"},  32'(out_illegal),   32'(h.ill));
        end
        push_ok = do_push && rdy && !do_flush && sb.size() < 8;
        pop_ok  = do_pop && rdy && !do_flush && sb.size() != 0;
        @(posedge clk_in);
        if (do_flush) begin
            sb.delete();
        end else begin
            if (pop_ok) void'(sb.pop_front());
            if (push_ok) sb.push_back(e);
        end
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush_in  = 1'b0;
    endtask

    exp_t none;

    initial begin
        none = mk(6'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_in = 1'b1; rdy_in = 1'b1; flush_in = 1'b0; in_valid = 1'b0;
        in_instr = 32'd0; in_pc = 32'd0; in_pred_jump = 1'b0; out_ready = 1'b0;
        #2;
        chk("rst.in_ready",  32'(in_ready),   32'd1);
        chk("rst.out_valid", 32'(out_valid),  32'd0);
        chk("rst.optype",    32'(out_optype), 32'd0);
        chk("rst.rd",        32'(out_rd),     32'd0);
        chk("rst.imm",       out_imm,         32'd0);
        chk("rst.pc",        out_pc,          32'd0);
        @(posedge clk_in); #1;
        rst_in = 1'b0;
        @(posedge clk_in); #1;

        // Single pushes, each visible the cycle after the push
        step("addi_push", 1'b1, 32'h0050_0093, addi_exp(12'd5, 32'h0000_1000), 1'b0, 1'b0, 1'b1);
        step("addi_pop",  1'b0, 32'd0, none, 1'b1, 1'b0, 1'b1);
        step("lui_push",  1'b1, 32'h1234_5137,
             mk(OPTYPE_LUI, 5'd2, 5'd0, 5'd0, 32'h1234_5000, 32'h0000_1004, 1'b0, 1'b0, 1'b0, 1'b0),
             1'b0, 1'b0, 1'b1);
        step("lui_pop",   1'b0, 32'd0, none, 1'b1, 1'b0, 1'b1);
        step("jal_push",  1'b1, 32'hFFDF_F0EF,
             mk(OPTYPE_JAL, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFC, 32'h0000_1008, 1'b1, 1'b0, 1'b1, 1'b0),
             1'b0, 1'b0, 1'b1);
        step("jal_pop",   1'b0, 32'd0, none, 1'b1, 1'b0, 1'b1);
        step("sw_push",   1'b1, 32'h0051_2423,
             mk(OPTYPE_SW, 5'd0, 5'd2, 5'd5, 32'h0000_0008, 32'h0000_100C, 1'b0, 1'b1, 1'b0, 1'b0),
             1'b0, 1'b0, 1'b1);
        step("sw_pop",    1'b0, 32'd0, none, 1'b1, 1'b0, 1'b1);

        // Fill to 8, attempt a 9th, then drain across the pointer wrap
        for (int k = 0; k < 9; k++) begin
            step("fill", 1'b1, addi_instr(12'(k + 16)),
                 addi_exp(12'(k + 16), 32'h100 + 32'(4 * k)), 1'b0, 1'b0, 1'b1);
        end
        for (int k = 0; k < 9; k++) begin
            step("drain", 1'b0, 32'd0, none, 1'b1, 1'b0, 1'b1);
        end

        // Steady state at count 4 with simultaneous push and pop
        for (int k = 0; k < 4; k++) begin
            step("pre4", 1'b1, addi_instr(12'(k + 40)),
                 addi_exp(12'(k + 40), 32'h200 + 32'(4 * k)), 1'b0, 1'b0, 1'b1);
        end
        for (int k = 4; k < 10; k++) begin
            step("pushpop", 1'b1, addi_instr(12'(k + 40)),
                 addi_exp(12'(k + 40), 32'h200 + 32'(4 * k)), 1'b1, 1'b0, 1'b1);
        end
        for (int k = 0; k < 5; k++) begin
            step("pp_drain", 1'b0, 32'd0, none, 1'b1, 1'b0, 1'b1);
        end

        // Flush at count 5 with a concurrent push
        for (int k = 0; k < 5; k++) begin
            step("pre_flush", 1'b1, addi_instr(12'(k + 60)),
                 addi_exp(12'(k + 60), 32'h300 + 32'(4 * k)), 1'b0, 1'b0, 1'b1);
        end
        step("flush", 1'b1, addi_instr(12'd99), addi_exp(12'd99, 32'h0000_0999), 1'b0, 1'b1, 1'b1);
        step("post_flush", 1'b1, addi_instr(12'd77), addi_exp(12'd77, 32'h0000_0500), 1'b0, 1'b0, 1'b1);
        step("post_flush_pop", 1'b0, 32'd0, none, 1'b1, 1'b0, 1'b1);

        // Illegal branch funct3 plus a legal follower, frozen for 3 cycles
        step("ill_push", 1'b1, 32'h0000_A063,
             mk(OPTYPE_NOP, 5'd0, 5'd0, 5'd0, 32'd0, 32'h0000_0600, 1'b1, 1'b0, 1'b0, 1'b1),
             1'b0, 1'b0, 1'b1);
        step("ill_next", 1'b1, addi_instr(12'hFFF), addi_exp(12'hFFF, 32'h0000_0604), 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            step("frozen", 1'b1, addi_instr(12'd3), addi_exp(12'd3, 32'h0000_0700), 1'b1, 1'b0, 1'b0);
        end
        step("ill_pop",  1'b0, 32'd0, none, 1'b1, 1'b0, 1'b1);
        step("next_pop", 1'b0, 32'd0, none, 1'b1, 1'b0, 1'b1);
        step("final",    1'b0, 32'd0, none, 1'b0, 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
